// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU, the host port, the shared data memory and
// dmem_arbiter. The slave modport is the arbiter's view; the master modport
// is the view of the surrounding environment (CPU, host bridge and memory).
interface dmem_arbiter_if;
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_stall;

   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic [7:0] host_rdata;

   logic [7:0] mem_addr;
   logic [7:0] mem_w_data;
   logic       mem_w_en;
   logic [7:0] mem_r_data;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_rdata,
      output mem_addr, mem_w_data, mem_w_en,
      input  mem_r_data
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_rdata,
      input  mem_addr, mem_w_data, mem_w_en,
      output mem_r_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (priority,
// combinational path) and a host port (served in CPU-idle cycles, one-cycle
// ack with registered read data).
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN:
// a host denied MAX_WAIT cycles in WAIT is granted over the CPU for one cycle.
module dmem_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input logic           clock,
   input logic           reset_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hostRdata_q, hostRdata_d;
   logic       hostGrant;
   logic       starve;

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gBadMaxWait
      $error("dmem_arbiter: MAX_WAIT must be in 1..15");
   end

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

   logic [3:0] waitCnt_q, waitCnt_d;

   assign starve = (state_q == ST_WAIT) && (waitCnt_q == MaxWaitC);
`else
   assign starve = 1'b0;
`endif

   // Host wins the memory when the CPU is idle or the host has starved;
   // never in the ACK cycle and never while reset is held.
   assign hostGrant = reset_n && bus.host_req && (state_q != ST_ACK) &&
                      (!bus.cpu_req || starve);

   // State register and captured host read data
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         hostRdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         hostRdata_q <= hostRdata_d;
      end
   end

   // Next-state logic; read data is captured before any same-edge write lands
   always_comb begin
      state_d     = state_q;
      hostRdata_d = hostRdata_q;
      case (state_q)
         ST_IDLE: begin
            if (hostGrant) begin
               state_d     = ST_ACK;
               hostRdata_d = bus.mem_r_data;
            end else if (bus.host_req) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (hostGrant) begin
               state_d     = ST_ACK;
               hostRdata_d = bus.mem_r_data;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef DMEM_ARB_STARVE_GUARD_EN
   // Count consecutive denied host cycles, saturating at MAX_WAIT
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         waitCnt_q <= 4'd0;
      end else begin
         waitCnt_q <= waitCnt_d;
      end
   end

   // Wait counter next value: clear on grant, start at 1 on first denial
   always_comb begin
      waitCnt_d = waitCnt_q;
      if (hostGrant) begin
         waitCnt_d = 4'd0;
      end else if (state_q == ST_IDLE && bus.host_req) begin
         waitCnt_d = 4'd1;
      end else if (state_q == ST_WAIT && waitCnt_q != MaxWaitC) begin
         waitCnt_d = waitCnt_q + 4'd1;
      end
   end
`endif

   // Memory mux, stall, ack and read-data outputs
   always_comb begin
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_w_data = bus.cpu_wdata;
      bus.mem_w_en   = reset_n && bus.cpu_req && bus.cpu_we;
      if (hostGrant) begin
         bus.mem_addr   = bus.host_addr;
         bus.mem_w_data = bus.host_wdata;
         bus.mem_w_en   = bus.host_we;
      end
`ifdef DMEM_ARB_STARVE_GUARD_EN
      bus.cpu_stall  = bus.cpu_req && hostGrant;
`else
      bus.cpu_stall  = 1'b0;
`endif
      bus.cpu_rdata  = bus.mem_r_data;
      bus.host_ack   = (state_q == ST_ACK);
      bus.host_rdata = hostRdata_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// single-port memory (combinational read, posedge write). Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// Expectations follow DMEM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_dmem_arbiter;

   logic clock;
   logic reset_n;
   int   vectors;
   int   miscompares;

   logic [7:0] memArray [256];

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_WAIT(4)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // Free-running 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural data memory shared through the arbiter
   always @(posedge clock) begin
      if (bus.mem_w_en) memArray[bus.mem_addr] <= bus.mem_w_data;
   end
   assign bus.mem_r_data = memArray[bus.mem_addr];

   task automatic applyStimulus(input logic cReq, input logic cWe,
                                input logic [7:0] cAddr, input logic [7:0] cWdata,
                                input logic hReq, input logic hWe,
                                input logic [7:0] hAddr, input logic [7:0] hWdata);
      bus.cpu_req    = cReq;
      bus.cpu_we     = cWe;
      bus.cpu_addr   = cAddr;
      bus.cpu_wdata  = cWdata;
      bus.host_req   = hReq;
      bus.host_we    = hWe;
      bus.host_addr  = hAddr;
      bus.host_wdata = hWdata;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Directed sequence
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      applyStimulus(1'b1, 1'b1, 8'h55, 8'hEE, 1'b1, 1'b1, 8'h66, 8'hDD);

      // Reset held: outputs forced quiet even with CPU and host requesting
      @(negedge clock);
      checkOutput("rst_wen", bus.mem_w_en, 8'd0);
      checkOutput("rst_stall", bus.cpu_stall, 8'd0);
      checkOutput("rst_ack", bus.host_ack, 8'd0);
      checkOutput("rst_rdata", bus.host_rdata, 8'h00);

      nextCycle();
      reset_n = 1'b1;
      $display("[TB] uncontended host write then read");
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
      @(negedge clock);
      checkOutput("wr_wen", bus.mem_w_en, 8'd1);
      checkOutput("wr_addr", bus.mem_addr, 8'h10);
      checkOutput("wr_wdata", bus.mem_w_data, 8'hA5);
      checkOutput("wr_ack_early", bus.host_ack, 8'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("wr_ack", bus.host_ack, 8'd1);
      checkOutput("wr_ack_wen", bus.mem_w_en, 8'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      @(negedge clock);
      checkOutput("rd_ack_early", bus.host_ack, 8'd0);
      checkOutput("rd_wen", bus.mem_w_en, 8'd0);
      checkOutput("rd_addr", bus.mem_addr, 8'h10);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("rd_ack", bus.host_ack, 8'd1);
      checkOutput("rd_rdata", bus.host_rdata, 8'hA5);

      // CPU busy writing 0x3C to 0x20 while host reads 0x20
      nextCycle();
      $display("[TB] host waits behind busy CPU");
      applyStimulus(1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b0, 8'h20, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput("busy_wen", bus.mem_w_en, 8'd1);
         checkOutput("busy_wdata", bus.mem_w_data, 8'h3C);
         checkOutput("busy_stall", bus.cpu_stall, 8'd0);
         checkOutput("busy_ack", bus.host_ack, 8'd0);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
      @(negedge clock);
      checkOutput("busy_grant_addr", bus.mem_addr, 8'h20);
      checkOutput("busy_grant_wen", bus.mem_w_en, 8'd0);
      checkOutput("busy_grant_ack", bus.host_ack, 8'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("busy_ack_done", bus.host_ack, 8'd1);
      checkOutput("busy_rdata", bus.host_rdata, 8'h3C);

      // CPU writes 0x77 to 0x30 every cycle; host reads 0x10 meanwhile
      nextCycle();
      applyStimulus(1'b1, 1'b1, 8'h30, 8'h77, 1'b1, 1'b0, 8'h10, 8'h00);
`ifdef DMEM_ARB_STARVE_GUARD_EN
      $display("[TB] starvation guard enabled");
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("starve_pre_stall", bus.cpu_stall, 8'd0);
         checkOutput("starve_pre_ack", bus.host_ack, 8'd0);
         checkOutput("starve_pre_wen", bus.mem_w_en, 8'd1);
         nextCycle();
      end
      @(negedge clock);
      checkOutput("starve_stall", bus.cpu_stall, 8'd1);
      checkOutput("starve_addr", bus.mem_addr, 8'h10);
      checkOutput("starve_wen", bus.mem_w_en, 8'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("starve_ack", bus.host_ack, 8'd1);
      checkOutput("starve_rdata", bus.host_rdata, 8'hA5);
      checkOutput("starve_post_stall", bus.cpu_stall, 8'd0);
      checkOutput("starve_retry_wen", bus.mem_w_en, 8'd1);
      checkOutput("starve_retry_addr", bus.mem_addr, 8'h30);
      nextCycle();
`else
      $display("[TB] starvation guard disabled");
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         checkOutput("noguard_stall", bus.cpu_stall, 8'd0);
         checkOutput("noguard_ack", bus.host_ack, 8'd0);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      @(negedge clock);
      checkOutput("noguard_grant_addr", bus.mem_addr, 8'h10);
      checkOutput("noguard_grant_wen", bus.mem_w_en, 8'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("noguard_ack_done", bus.host_ack, 8'd1);
      checkOutput("noguard_rdata", bus.host_rdata, 8'hA5);
      nextCycle();
`endif

      // Read back 0x30: CPU write must have landed
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
      @(negedge clock);
      checkOutput("rb_cpu_rdata", bus.cpu_rdata, 8'h77);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("rb_ack", bus.host_ack, 8'd1);
      checkOutput("rb_rdata", bus.host_rdata, 8'h77);

      // Host holds request through ACK: second write 2 cycles after the first
      nextCycle();
      $display("[TB] back-to-back host writes");
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h5A);
      @(negedge clock);
      checkOutput("b2b_wen0", bus.mem_w_en, 8'd1);
      checkOutput("b2b_ack0", bus.host_ack, 8'd0);
      nextCycle();
      @(negedge clock);
      checkOutput("b2b_ack1", bus.host_ack, 8'd1);
      checkOutput("b2b_wen1", bus.mem_w_en, 8'd0);
      nextCycle();
      @(negedge clock);
      checkOutput("b2b_wen2", bus.mem_w_en, 8'd1);
      checkOutput("b2b_ack2", bus.host_ack, 8'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("b2b_ack3", bus.host_ack, 8'd1);
      checkOutput("b2b_prewrite", bus.host_rdata, 8'h5A);

      // Reset asserted while the host waits behind a writing CPU
      nextCycle();
      $display("[TB] reset during WAIT");
      applyStimulus(1'b1, 1'b1, 8'h50, 8'h99, 1'b1, 1'b0, 8'h40, 8'h00);
      nextCycle();
      reset_n = 1'b0;
      #1;
      checkOutput("rstw_wen", bus.mem_w_en, 8'd0);
      checkOutput("rstw_ack", bus.host_ack, 8'd0);
      checkOutput("rstw_stall", bus.cpu_stall, 8'd0);
      @(negedge clock);
      checkOutput("rstw_rdata", bus.host_rdata, 8'h00);
      nextCycle();
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checkOutput("rstw_no_ack", bus.host_ack, 8'd0);
         checkOutput("rstw_hold_rdata", bus.host_rdata, 8'h00);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'hC3);
      @(negedge clock);
      checkOutput("post_rst_wen", bus.mem_w_en, 8'd1);
      checkOutput("post_rst_ack0", bus.host_ack, 8'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      checkOutput("post_rst_ack1", bus.host_ack, 8'd1);

      nextCycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the jacaranda-8 single-port data memory (combinational read, posedge write) between the CPU and a host-side port, e.g. a Caravel Wishbone bridge or loader. The CPU has priority and is never delayed in normal operation. The host is served in cycles where the CPU does not access memory, and receives a one-cycle ack with registered read data. An optional starvation guard stalls the CPU for one cycle when a host request has waited too long.

## Interface
Parameters:
- MAX_WAIT, 4: consecutive denied host cycles before the starvation guard fires (1–15).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU accesses memory this cycle
- cpu_we  in  1  CPU write
- cpu_addr  in  8  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  mem_r_data passthrough; valid only when cpu_stall=0
- cpu_stall  out  1  CPU access not performed; CPU holds its request and retries next cycle
- host_req  in  1  host request; held until host_ack
- host_we  in  1  host write
- host_addr  in  8  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  read data captured at completion
- mem_addr  out  8  to memory addr
- mem_w_data  out  8  to memory w_data
- mem_w_en  out  1  to memory w_en
- mem_r_data  in  8  from memory r_data

## Operation
- FSM states:
  - IDLE: no host transaction pending.
  - WAIT: host pending and denied at least once.
  - ACK: host_ack=1.
- host_grant (combinational) = host_req && state!=ACK && (!cpu_req || starve).
- starve = (state==WAIT && wait_cnt==MAX_WAIT); it is forced to 0 when the guard is compiled out.
- When host_grant=1: mem_* driven from host_*, and mem_w_en=host_we. Otherwise mem_* driven from cpu_*, and mem_w_en=cpu_req && cpu_we.
- cpu_stall = cpu_req && host_grant.
- Transitions:
  - IDLE or WAIT, host_grant: go to ACK, host_rdata<=mem_r_data, wait_cnt<=0.
  - IDLE, host_req && !host_grant: go to WAIT, wait_cnt<=1.
  - WAIT, !host_grant: stay in WAIT, wait_cnt saturates at MAX_WAIT.
  - ACK: go to IDLE unconditionally. host_req is ignored in this cycle.
- host_rdata is updated on writes too, with the pre-write contents of the addressed location. It holds its value between acks.
- While reset_n=0: mem_w_en=0, cpu_stall=0, host_grant=0.
- Reset at any time, including mid-transaction:
  - state=IDLE, wait_cnt=0, host_ack=0, host_rdata=8'h00.
  - Any pending host transaction is dropped with no ack.
- Host protocol:
  - The host holds host_req, host_we, host_addr and host_wdata stable until host_ack.
  - A host_req still high in the ACK cycle is ignored. If it is still high the cycle after, it starts a new transaction.

## Timing
- Uncontended host access: request cycle N is granted, memory written at edge N→N+1, host_ack=1 in cycle N+1. Latency is 1 cycle.
- With CPU busy, host_ack follows 1 cycle after the first granted cycle.
- Maximum host latency is MAX_WAIT+1 cycles with the guard in. It is unbounded without the guard.
- Minimum host issue interval is 2 cycles (request, ack).
- CPU path is combinational (cpu_* to mem_*, mem_r_data to cpu_rdata). The CPU adds no latency when not stalled.
- cpu_stall is combinational from cpu_req, host_req, state and wait_cnt.
- wait_cnt is 4 bits.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - starve logic is active.
  - A host denied MAX_WAIT consecutive cycles in WAIT is granted the next cycle over the CPU, with cpu_stall=1 for exactly that cycle.
- Undefined:
  - starve=0, wait_cnt is not implemented, and cpu_stall is tied 0.
  - The host is served only in cycles with cpu_req=0.

## Test plan
- Reset, then host write 8'hA5 to 8'h10 with cpu_req=0 → mem_w_en=1 in the request cycle, host_ack pulses 1 cycle later. A following host read of 8'h10 returns host_rdata=8'hA5 with ack.
- CPU writes 8'h3C to 8'h20 with cpu_req=1 every cycle while the host reads 8'h20 → host waits. Once cpu_req drops, grant occurs that cycle, ack follows, host_rdata=8'h3C.
- Guard enabled, MAX_WAIT=4, cpu_req held 1 with a host read pending → exactly one cpu_stall cycle after 4 denied WAIT cycles, host_ack the next cycle, and no CPU write is lost once the CPU retries.
- Guard disabled, same stimulus for 100 cycles → cpu_stall=0 and host_ack=0 throughout.
- Host holds host_req through the ACK cycle → ACK cycle ignores it, a second transaction is granted the cycle after, so acks are spaced by 2 cycles.
- reset_n asserted while in WAIT with cpu_req=1 and cpu_we=1 → mem_w_en=0 and host_ack=0 immediately. After release, state is IDLE, host_rdata=8'h00, and no ack is produced for the dropped request.
